// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI serf.
package spi_pkg;

  localparam int SPI_WORD_W     = 16;
  localparam int SPI_SYNC_DEPTH = 3;

  typedef logic [1:0] spi_serf_state_t;

  localparam spi_serf_state_t ST_IDLE      = 2'd0;
  localparam spi_serf_state_t ST_WAIT_RISE = 2'd1;
  localparam spi_serf_state_t ST_WAIT_FALL = 2'd2;

endpackage

// File: rtl/spi_serf_sync_edge.sv
// sync_edge: metastability synchronizer with edge detect on the last two stages.
// Latency: q and rise/fall are valid two clk edges after the pin is captured.
// Backpressure: none; a free-running pipeline.
module sync_edge
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic rst_val,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {SPI_SYNC_DEPTH{rst_val}};
    else        ff <= {ff[SPI_SYNC_DEPTH-2:0], d};
  end

  assign q    = ff[SPI_SYNC_DEPTH-2];
  assign rise =  q & ~ff[SPI_SYNC_DEPTH-1];
  assign fall = ~q &  ff[SPI_SYNC_DEPTH-1];

endmodule

// File: rtl/spi_serf.sv
// spi_serf: mode-3 SPI responder, one 16-bit MSB-first word per SS_n-low frame.
// Latency: pin-to-action 3 clk edges; rdy/frm_err register 3 edges after the SS_n pin rise.
// Backpressure: none on the link; an unread rx_data is overwritten and flagged by ovr.
module spi_serf
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  wrt,
  input  logic [SPI_WORD_W-1:0] tx_data,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rdy,
  input  logic                  clr_rdy,
  output logic                  ovr,
  output logic                  frm_err
);

  logic ss_q, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, mosi_q;
  logic [2:0] sync_unused;

  sync_edge u_ss   (.clk(clk), .rst_n(rst_n), .d(SS_n), .rst_val(1'b1),
                    .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK), .rst_val(1'b1),
                    .q(sync_unused[0]), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge u_mosi (.clk(clk), .rst_n(rst_n), .d(MOSI), .rst_val(1'b0),
                    .q(mosi_q), .rise(sync_unused[1]), .fall(sync_unused[2]));

  spi_serf_state_t       state;
  logic [SPI_WORD_W-1:0] shft_reg, tx_buf, shifted, frm_word;
  logic [4:0]            bit_cnt, eff_cnt;
  logic                  mosi_smpl, can_shift, do_shift, frm_end, frm_ok;

  // The monarch raises SS_n without a last SCLK fall, so ss_rise in WAIT_FALL
  // stands in for that fall and completes the pending shift.
  assign can_shift = (state == ST_WAIT_FALL) && (bit_cnt < 5'd16);
  assign do_shift  = can_shift && (sclk_fall || ss_rise);
  assign shifted   = {shft_reg[SPI_WORD_W-2:0], mosi_smpl};
  assign frm_end   = (state != ST_IDLE) && ss_rise;
  assign eff_cnt   = bit_cnt + {4'd0, can_shift};
  assign frm_ok    = frm_end && (eff_cnt == 5'd16);
  assign frm_word  = can_shift ? shifted : shft_reg;

  assign MISO = ss_q ? 1'bz : shft_reg[SPI_WORD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tx_buf <= '0;
    else if (wrt) tx_buf <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shft_reg  <= '0;
      bit_cnt   <= '0;
      mosi_smpl <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (ss_fall) begin
          shft_reg <= tx_buf;
          bit_cnt  <= '0;
          state    <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (ss_rise) state <= ST_IDLE;
          else if (sclk_rise) begin
            mosi_smpl <= mosi_q;
            state     <= ST_WAIT_FALL;
          end
        end
        ST_WAIT_FALL: begin
          if (ss_rise)        state <= ST_IDLE;
          else if (sclk_fall) state <= ST_WAIT_RISE;
        end
        default: state <= ST_IDLE;
      endcase
      if (do_shift) begin
        shft_reg <= shifted;
        bit_cnt  <= bit_cnt + 5'd1;
      end
    end
  end

  // A completing frame wins over clr_rdy for rdy; clr_rdy still suppresses ovr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      ovr     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      frm_err <= frm_end && !frm_ok;
      if (frm_ok) begin
        rx_data <= frm_word;
        rdy     <= 1'b1;
        if (clr_rdy)  ovr <= 1'b0;
        else if (rdy) ovr <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: a 16-bit mode-3 monarch driving frames, with a frame-level reference model.
module tb_spi_serf;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0, wrt = 1'b0, clr_rdy = 1'b0;
  logic [15:0] tx_data = 16'h0;
  wire         MISO;
  logic [15:0] rx_data;
  logic        rdy, ovr, frm_err;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_serf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wrt(wrt), .tx_data(tx_data), .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy),
    .ovr(ovr), .frm_err(frm_err)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame end takes effect on the 3rd clk rise after the SS_n pin rise.
  logic [15:0] m_rx = 16'h0, m_txbuf = 16'h0, m_word = 16'h0;
  logic        m_rdy = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  int          m_cnt = 0, m_end = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rx = 16'h0; m_txbuf = 16'h0; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_end = 0;
    end else begin
      m_ferr = 1'b0;
      if (m_end == 1 && m_cnt == 16) begin
        if (clr_rdy)    m_ovr = 1'b0;
        else if (m_rdy) m_ovr = 1'b1;
        m_rx  = m_word;
        m_rdy = 1'b1;
      end else begin
        if (m_end == 1) m_ferr = 1'b1;
        if (clr_rdy) begin m_rdy = 1'b0; m_ovr = 1'b0; end
      end
      if (m_end > 0) m_end--;
      if (wrt) m_txbuf = tx_data;
    end
  end

  bit cmp_en = 1'b0;
  int ferr_pulses = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rx_data", rx_data, m_rx);
      chk("rdy", {15'd0, rdy}, {15'd0, m_rdy});
      chk("ovr", {15'd0, ovr}, {15'd0, m_ovr});
      chk("frm_err", {15'd0, frm_err}, {15'd0, m_ferr});
      if (frm_err) ferr_pulses++;
    end
  end

  logic [15:0] last_rd;

  task automatic wr(input logic [15:0] v);
    @(negedge clk); wrt = 1'b1; tx_data = v;
    @(negedge clk); wrt = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk); clr_rdy = 1'b1;
    @(negedge clk); clr_rdy = 1'b0;
  endtask

  // One monarch frame: SCLK half period 16 clks, leading fall, nrise rising edges.
  task automatic frame(input logic [15:0] word, input int nrise, input bit clr_at_end);
    logic [15:0] rd, exp_tx;
    rd = 16'h0;
    @(negedge clk); SS_n = 1'b0;
    repeat (16) @(negedge clk);
    exp_tx = m_txbuf;
    SCLK = 1'b0; MOSI = word[15];
    for (int i = 0; i < nrise; i++) begin
      repeat (16) @(negedge clk);
      SCLK = 1'b1; rd = {rd[14:0], MISO};
      if (i < nrise - 1) begin
        repeat (16) @(negedge clk);
        SCLK = 1'b0; MOSI = word[14-i];
      end
    end
    repeat (16) @(negedge clk);
    m_word = word; m_cnt = nrise; m_end = 3;
    SS_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (clr_at_end) clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    SCLK = 1'b1;
    repeat (6) @(negedge clk);
    last_rd = rd;
    if (nrise == 16) chk("rd_data", rd, exp_tx);
  endtask

  initial begin
    logic [15:0] w;
    int n;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_rx", rx_data, 16'h0000);
    chk("reset_rdy", {15'd0, rdy}, 16'h0);

    // Basic exchange
    wr(16'h3C5A);
    frame(16'hA5C3, 16, 1'b0);
    chk("t1_rx", rx_data, 16'hA5C3);
    chk("t1_rdy", {15'd0, rdy}, 16'h1);
    chk("t1_rd", last_rd, 16'h3C5A);
    chk("t1_ovr", {15'd0, ovr}, 16'h0);
    clr();

    // Overrun then clear
    frame(16'h1234, 16, 1'b0);
    frame(16'hFFFF, 16, 1'b0);
    chk("t2_rx", rx_data, 16'hFFFF);
    chk("t2_ovr", {15'd0, ovr}, 16'h1);
    clr();
    @(negedge clk);
    chk("t2_clr_rdy", {15'd0, rdy}, 16'h0);
    chk("t2_clr_ovr", {15'd0, ovr}, 16'h0);

    // wrt mid-frame affects only the next frame
    wr(16'h0001);
    fork
      frame(16'h5555, 16, 1'b0);
      begin repeat (200) @(negedge clk); wr(16'hBEEF); end
    join
    chk("t3_rd_cur", last_rd, 16'h0001);
    frame(16'h6666, 16, 1'b0);
    chk("t3_rd_next", last_rd, 16'hBEEF);
    clr();

    // Short frame
    ferr_pulses = 0;
    frame(16'h7777, 7, 1'b0);
    chk("t4_pulses", ferr_pulses[15:0], 16'd1);
    chk("t4_rdy", {15'd0, rdy}, 16'h0);
    chk("t4_rx", rx_data, 16'h6666);
    frame(16'h0F0F, 16, 1'b0);
    chk("t4_next_rx", rx_data, 16'h0F0F);

    // clr_rdy coincident with completion while rdy already set
    frame(16'h2468, 16, 1'b1);
    chk("t5_rdy", {15'd0, rdy}, 16'h1);
    chk("t5_ovr", {15'd0, ovr}, 16'h0);
    chk("t5_rx", rx_data, 16'h2468);

    // Reset mid-frame
    @(negedge clk); SS_n = 1'b0;
    repeat (16) @(negedge clk); SCLK = 1'b0; MOSI = 1'b1;
    repeat (16) @(negedge clk); SCLK = 1'b1;
    repeat (16) @(negedge clk); SCLK = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rx", rx_data, 16'h0000);
    chk("t6_rdy", {15'd0, rdy}, 16'h0);
    chk("t6_ovr", {15'd0, ovr}, 16'h0);
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame(16'h8001, 16, 1'b0);
    chk("t6_next_rx", rx_data, 16'h8001);
    chk("t6_rd", last_rd, 16'h0000);

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) wr(16'($urandom));
      if ($urandom_range(0, 2) == 0) clr();
      w = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      frame(w, n, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_serf.md
# spi_serf

SPI responder (serf) for the team's 16-bit SPI monarch. Mode 3: SCLK idles high, data changes on the SCLK fall and is sampled on the SCLK rise, MSB first, one 16-bit word per SS_n-low frame. The block receives the MOSI word into `rx_data` with a `rdy`/`clr_rdy` handshake, and returns a locally buffered `tx_data` word on MISO. It sits on the serf side of any SPI link driven by the monarch, for example an inertial-sensor model or a loop-back bench.

## Interface
- No parameters. Word width is fixed at 16.
- `clk` input 1: system clock. Must be at least 8× SCLK; the monarch's SCLK is clk/32.
- `rst_n` input 1: asynchronous active-low reset.
- `SS_n` input 1: serf select, active low, asynchronous to clk.
- `SCLK` input 1: serial clock, asynchronous to clk.
- `MOSI` input 1: serial data from the monarch.
- `MISO` output 1: serial data to the monarch. Equals `shft_reg[15]` while the synchronized SS_n is low, high-Z otherwise.
- `wrt` input 1: loads `tx_data` into `tx_buf`.
- `tx_data` input 16: response word.
- `rx_data` output 16: last complete received word.
- `rdy` output 1: a new `rx_data` word is available.
- `clr_rdy` input 1: consumer acknowledge; clears `rdy` and `ovr`.
- `ovr` output 1: sticky flag; a frame completed while `rdy` was already set.
- `frm_err` output 1: one-clk pulse when a frame ends with a shift count other than 16.

## Operation
- Synchronizers
  - SS_n, SCLK and MOSI each pass through 3 flops: 2 for metastability, 1 for edge detect.
  - SS_n and SCLK sync flops reset to 1; MOSI sync flops reset to 0.
  - `sclk_rise`, `sclk_fall`, `ss_fall` and `ss_rise` are each derived from the 2nd vs 3rd flop.
- State machine: IDLE, WAIT_RISE, WAIT_FALL.
  - IDLE: on `ss_fall`, load `shft_reg` ← `tx_buf`, clear `bit_cnt`, and go to WAIT_RISE.
  - WAIT_RISE: `sclk_fall` is ignored; this absorbs the monarch's leading SCLK fall. On `sclk_rise`, `MOSI_smpl` ← synchronized MOSI and go to WAIT_FALL.
  - WAIT_FALL: on `sclk_fall`, `shft_reg` ← {`shft_reg[14:0]`, `MOSI_smpl`}, increment `bit_cnt`, and go to WAIT_RISE.
  - Any non-IDLE state: `ss_rise` ends the frame and returns to IDLE.
- Final shift
  - The monarch raises SS_n without a final SCLK fall.
  - If `ss_rise` occurs in WAIT_FALL, perform the pending shift in that same cycle.
  - The effective count is `bit_cnt + 1`, and the capture uses the shifted value.
- Frame end
  - Effective count == 16: `rx_data` ← received word and `rdy` ← 1. If `rdy` was already 1 and `clr_rdy` is not asserted, `ovr` ← 1.
  - Any other count, including 0: pulse `frm_err`; `rx_data` and `rdy` are unchanged.
- `bit_cnt` is 5 bits. It saturates at 16; surplus edges do not shift further.
- `tx_buf`
  - Updated only by `wrt`.
  - A `wrt` during a frame affects the next frame only.
  - The word is retained and resent if there is no new `wrt`.
- Collisions
  - `clr_rdy` coincident with a frame completion: set wins, so `rdy` = 1 and `ovr` = 0.
  - `ss_fall` and `ss_rise` cannot both occur in one cycle, by construction of the edge detect.
- Reset mid-frame: the block immediately returns to IDLE with every output at its reset value. The next frame is accepted only after a clean SS_n fall.
- Reset values: `rx_data` 0, `tx_buf` 0, `shft_reg` 0, `rdy` 0, `ovr` 0, `frm_err` 0, MISO high-Z.

## Timing
- Pin-to-detect latency is 3 clk edges: pin captured at edge n, action registered at edge n+2.
- `shft_reg` is loaded at edge n+2 after the SS_n fall. The first MISO bit is valid more than 20 clks before the monarch's first SCLK rise.
- MISO changes 3 clks after each SCLK fall, well inside the 16-clk half period, so MOSI and MISO meet the monarch's sample on the rise.
- `rdy` rises at edge n+2 after the SS_n pin rise.
- `frm_err` is a single-cycle pulse on the same edge that `rdy` would have risen.
- `rdy` falls on the edge after `clr_rdy` is sampled high.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_serf_state_t`
  - `SPI_WORD_W` = 16
  - synchronizer depth = 3
- Natural sub-module: `sync_edge`, a 3-flop synchronizer with a reset-value port and rise/fall outputs, instantiated 3 times.
- The rest (FSM, shift register, counter, handshake) stays in `spi_serf`.

## Test plan
- Monarch writes 0xA5C3 with `tx_buf` = 0x3C5A → `rx_data` = 0xA5C3, `rdy` = 1, monarch `rd_data` = 0x3C5A, `ovr` = 0, `frm_err` = 0.
- Two frames, 0x1234 then 0xFFFF, with no `clr_rdy` between them → `rx_data` = 0xFFFF, `ovr` = 1. A following `clr_rdy` clears both `rdy` and `ovr`.
- `wrt` of 0xBEEF mid-frame while 0x0001 is being sent → this frame returns 0x0001, the next frame returns 0xBEEF.
- SS_n raised after 7 SCLK rises → `frm_err` pulses once, `rdy` stays 0, `rx_data` is unchanged, and the next full frame is received correctly.
- `clr_rdy` asserted in the same cycle as a frame completion → `rdy` = 1, `ovr` = 0.
- `rst_n` pulsed low mid-frame → all outputs return to reset values, and the next frame 0x8001 is received correctly.
